bnn_maxpool_bin: RTL and testbench



---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_pool_window.sv | 36 +++
 rtl/bnn_maxpool_bin.sv | 131 +++++++++++++
 tb/tb_bnn_maxpool_bin.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the binary max-pooling stage.
// Optional feature macro used by the pooling top: BNN_POOL_PERF_EN.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POOL = 2'd1,
        S_DONE = 2'd2,
        S_WAIT = 2'd3
    } pool_state_t;

    function automatic int pool_out_size(input int n);
        return n / 2;
    endfunction

    // Index width that stays at least 1 bit even for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_pool_window.sv
// Combinational 2x2 OR window: one pooled bit per channel for output pixel (row, col).
module bnn_pool_window
    import bnn_pkg::*;
#(
    parameter int C           = 8,
    parameter int IMG_IN_SIZE = 28,
    parameter int RW          = 4
) (
    input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] i_cap [0:C-1],
    input  logic [RW-1:0]                      i_row,
    input  logic [RW-1:0]                      i_col,
    output logic [C-1:0]                       o_bit
);

    localparam int IW = idx_width(IMG_IN_SIZE * IMG_IN_SIZE);

    logic [IW-1:0] w_i00;
    logic [IW-1:0] w_i01;
    logic [IW-1:0] w_i10;
    logic [IW-1:0] w_i11;

    // Top-left corner of the window is input pixel (2*row, 2*col).
    assign w_i00 = IW'(2 * int'(i_row) * IMG_IN_SIZE + 2 * int'(i_col));
    assign w_i01 = IW'(2 * int'(i_row) * IMG_IN_SIZE + 2 * int'(i_col) + 1);
    assign w_i10 = IW'((2 * int'(i_row) + 1) * IMG_IN_SIZE + 2 * int'(i_col));
    assign w_i11 = IW'((2 * int'(i_row) + 1) * IMG_IN_SIZE + 2 * int'(i_col) + 1);

    always_comb begin
        o_bit = '0;
        for (int ch = 0; ch < C; ch++) begin
            o_bit[ch] = i_cap[ch][w_i00] | i_cap[ch][w_i01]
                      | i_cap[ch][w_i10] | i_cap[ch][w_i11];
        end
    end

endmodule

// File: rtl/bnn_maxpool_bin.sv
// Binary 2x2/stride-2 max-pool over C maps, one output pixel per clock.
// Define BNN_POOL_PERF_EN to add the pool_cycles performance counter port.
module bnn_maxpool_bin
    import bnn_pkg::*;
#(
    parameter  int C            = 8,
    parameter  int IMG_IN_SIZE  = 28,
    localparam int IMG_OUT_SIZE = pool_out_size(IMG_IN_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_in_ready,
    input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in  [0:C-1],
    output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out [0:C-1],
    output logic                                 data_out_ready
`ifdef BNN_POOL_PERF_EN
    ,
    output logic [15:0]                          pool_cycles
`endif
);

    localparam int NIN  = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int NOUT = IMG_OUT_SIZE * IMG_OUT_SIZE;
    localparam int RW   = idx_width(IMG_OUT_SIZE);
    localparam int OW   = idx_width(NOUT);
    localparam logic [RW-1:0] LAST = RW'(IMG_OUT_SIZE - 1);

    pool_state_t   r_state;
    logic [NIN-1:0] r_cap [0:C-1];
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_col;
    logic [C-1:0]  w_bit;
    logic [OW-1:0] w_out_idx;
    logic          w_last;
    logic          w_capture;

    // The pixel index is kept as (row, col) so no divider is needed.
    assign w_out_idx = OW'(int'(r_row) * IMG_OUT_SIZE + int'(r_col));
    assign w_last    = (r_row == LAST) && (r_col == LAST);
    assign w_capture = (r_state == S_IDLE) && data_in_ready;

    bnn_pool_window #(
        .C           (C),
        .IMG_IN_SIZE (IMG_IN_SIZE),
        .RW          (RW)
    ) u_window (
        .i_cap (r_cap),
        .i_row (r_row),
        .i_col (r_col),
        .o_bit (w_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst && w_capture) begin
            for (int ch = 0; ch < C; ch++) r_cap[ch] <= img_in[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_row          <= '0;
            r_col          <= '0;
            data_out_ready <= 1'b0;
            for (int ch = 0; ch < C; ch++) img_out[ch] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    data_out_ready <= 1'b0;
                    if (data_in_ready) begin
                        r_state <= S_POOL;
                        r_row   <= '0;
                        r_col   <= '0;
                        for (int ch = 0; ch < C; ch++) img_out[ch] <= '0;
                    end
                end
                S_POOL: begin
                    if (!data_in_ready) begin
                        // Upstream withdrew the frame: discard partial output.
                        r_state <= S_IDLE;
                        r_row   <= '0;
                        r_col   <= '0;
                        for (int ch = 0; ch < C; ch++) img_out[ch] <= '0;
                    end else begin
                        for (int ch = 0; ch < C; ch++) img_out[ch][w_out_idx] <= w_bit[ch];
                        if (w_last) begin
                            r_state        <= S_DONE;
                            data_out_ready <= 1'b1;
                            r_row          <= '0;
                            r_col          <= '0;
                        end else if (r_col == LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    data_out_ready <= 1'b0;
                    r_state        <= data_in_ready ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (!data_in_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BNN_POOL_PERF_EN
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // Counter restarts in IDLE; an aborted frame never reaches the latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            pool_cycles <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == S_POOL && data_in_ready) begin
            r_cnt <= w_cnt_inc;
            if (w_last) pool_cycles <= w_cnt_inc;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_maxpool_bin.sv
// Self-checking bench for bnn_maxpool_bin (C=2, odd 5x5 input, 2x2 output).
module tb_bnn_maxpool_bin;

    localparam int C    = 2;
    localparam int IN   = 5;
    localparam int OS   = IN / 2;
    localparam int NIN  = IN * IN;
    localparam int NOUT = OS * OS;
    localparam int EW   = C * NOUT;

    logic           clk = 1'b0;
    logic           rst;
    logic           data_in_ready;
    logic [NIN-1:0] img_in  [0:C-1];
    logic [NOUT-1:0] img_out [0:C-1];
    logic           data_out_ready;
`ifdef BNN_POOL_PERF_EN
    logic [15:0]    pool_cycles;
`endif

    always #5 clk = ~clk;

    bnn_maxpool_bin #(
        .C           (C),
        .IMG_IN_SIZE (IN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_ready  (data_in_ready),
        .img_in         (img_in),
        .img_out        (img_out),
        .data_out_ready (data_out_ready)
`ifdef BNN_POOL_PERF_EN
        ,
        .pool_cycles    (pool_cycles)
`endif
    );

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: view each map as a 2D grid and take max (OR) of every 2x2 block.
    function automatic logic [EW-1:0] ref_pool(input logic [NIN-1:0] f0, input logic [NIN-1:0] f1);
        logic [EW-1:0]  res;
        logic [NIN-1:0] f [0:C-1];
        logic           grid [0:IN-1][0:IN-1];
        logic           m;
        res  = '0;
        f[0] = f0;
        f[1] = f1;
        for (int ch = 0; ch < C; ch++) begin
            for (int r = 0; r < IN; r++)
                for (int c = 0; c < IN; c++) grid[r][c] = f[ch][r*IN + c];
            for (int r = 0; r < OS; r++) begin
                for (int c = 0; c < OS; c++) begin
                    m = grid[2*r][2*c] | grid[2*r][2*c+1] | grid[2*r+1][2*c] | grid[2*r+1][2*c+1];
                    res[ch*NOUT + r*OS + c] = m;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [EW-1:0] pack_out();
        logic [EW-1:0] res;
        for (int ch = 0; ch < C; ch++) res[ch*NOUT +: NOUT] = img_out[ch];
        return res;
    endfunction

    // Monitor: every pulse must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (data_out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got pulse, expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                check("img_out", 64'(pack_out()), 64'(e));
`ifdef BNN_POOL_PERF_EN
                check("pool_cycles", 64'(pool_cycles), 64'(NOUT));
`endif
            end
        end
    end

    // mode 0: drop ready right after the pulse; 1: hold ready high (WAIT);
    // 2: assert rst in the DONE cycle, then leave ready high.
    task automatic run_frame(input logic [NIN-1:0] f0, input logic [NIN-1:0] f1, input int mode);
        int lat;
        img_in[0]     = f0;
        img_in[1]     = f1;
        data_in_ready = 1'b1;
        exp_q.push_back(ref_pool(f0, f1));
        @(posedge clk);
        @(negedge clk);
        img_in[0] = NIN'($urandom);
        img_in[1] = NIN'($urandom);
        check("cleared_on_capture", 64'(pack_out()), 64'(0));
        lat = 1;
        while (data_out_ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("pulse_latency", 64'(lat), 64'(NOUT + 1));
        if (mode == 0) begin
            data_in_ready = 1'b0;
            @(negedge clk);
            check("pulse_one_cycle", 64'(data_out_ready), 64'(0));
        end else if (mode == 1) begin
            @(negedge clk);
            check("pulse_one_cycle", 64'(data_out_ready), 64'(0));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            data_in_ready = 1'b0;
            @(negedge clk);
        end else begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_done_pulse", 64'(data_out_ready), 64'(0));
            check("rst_done_img", 64'(pack_out()), 64'(0));
            rst = 1'b0;
        end
    endtask

    task automatic abort_frame(input logic [NIN-1:0] f0, input logic [NIN-1:0] f1, input int j);
        img_in[0]     = f0;
        img_in[1]     = f1;
        data_in_ready = 1'b1;
        @(posedge clk);
        repeat (j) @(negedge clk);
        data_in_ready = 1'b0;
        @(negedge clk);
        check("abort_img", 64'(pack_out()), 64'(0));
        check("abort_no_pulse", 64'(data_out_ready), 64'(0));
`ifdef BNN_POOL_PERF_EN
        check("abort_pool_cycles", 64'(pool_cycles), 64'(NOUT));
`endif
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [NIN-1:0] edge_bits;
        rst           = 1'b1;
        data_in_ready = 1'b0;
        img_in[0]     = '0;
        img_in[1]     = '0;
        repeat (3) @(negedge clk);
        check("reset_pulse", 64'(data_out_ready), 64'(0));
        check("reset_img", 64'(pack_out()), 64'(0));
`ifdef BNN_POOL_PERF_EN
        check("reset_pool_cycles", 64'(pool_cycles), 64'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single set pixel at (0,0) on ch0 and at (3,3) on ch1, ready held high.
        run_frame(NIN'(1), NIN'(1) << (3*IN + 3), 1);
        check("directed_corner", 64'(pack_out()), 64'(8'b1000_0001));
        run_frame('0, '0, 0);
        check("all_zero", 64'(pack_out()), 64'(0));
        run_frame('1, '1, 0);
        check("all_ones", 64'(pack_out()), 64'(8'hFF));

        edge_bits = '0;
        for (int k = 0; k < IN; k++) begin
            edge_bits[4*IN + k] = 1'b1;
            edge_bits[k*IN + 4] = 1'b1;
        end
        run_frame(edge_bits, edge_bits, 0);
        check("odd_edge_ignored", 64'(pack_out()), 64'(0));

        repeat (3) @(negedge clk);
        check("img_out_hold", 64'(pack_out()), 64'(last_exp));

        abort_frame(NIN'($urandom), NIN'($urandom), 3);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0)
                abort_frame(NIN'($urandom), NIN'($urandom), $urandom_range(2, NOUT - 1));
            else
                run_frame(NIN'($urandom) & NIN'($urandom), NIN'($urandom) & NIN'($urandom),
                          $urandom_range(0, 1));
        end

        run_frame(NIN'($urandom), NIN'($urandom), 2);
        run_frame(NIN'($urandom) & NIN'($urandom), NIN'($urandom), 0);
        repeat (3) @(negedge clk);
        check("img_out_hold_end", 64'(pack_out()), 64'(last_exp));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
